pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer for the fetch stage. Replaces the plain PC register.
- Holds the PC with a configurable reset vector. Drives a valid/ready fetch handshake.
- Applies trap and branch redirects with fixed priority, and supports halt/resume.
- Keeps a circular history of the last HIST_DEPTH accepted fetch PCs for debug/exception reporting.

Parameters:
- ADDR_WIDTH, 32, PC width in bits.
- RESET_VECTOR, 32'h3000_0000, PC value loaded on reset; truncated to ADDR_WIDTH.
- INSTR_BYTES, 4, sequential increment; power of two, 1..8.
- HIST_DEPTH, 4, number of history entries; power of two, >=2.

Ports:
- clk  in  1  clock
- arst  in  1  synchronous active-high reset
- i_fetch_ready  in  1  fetch unit accepts o_pc this cycle
- i_stall  in  1  freeze sequential advance
- i_redirect_valid  in  1  branch/jump redirect request
- i_redirect_pc  in  ADDR_WIDTH  redirect target
- i_trap_valid  in  1  trap request
- i_trap_vector  in  ADDR_WIDTH  trap handler address
- i_halt_req  in  1  request halt
- i_resume  in  1  leave HALTED
- i_hist_idx  in  $clog2(HIST_DEPTH)  history read index; 0 = most recent
- o_pc  out  ADDR_WIDTH  current fetch PC
- o_pc_valid  out  1  o_pc is a valid fetch request
- o_misaligned  out  1  one-cycle pulse: redirect/trap target was misaligned
- o_halted  out  1  FSM is in HALTED
- o_hist_pc  out  ADDR_WIDTH  history entry selected by i_hist_idx (combinational read)
- o_hist_count  out  $clog2(HIST_DEPTH)+1  number of valid history entries, saturating

Behaviour:
- Reset: reset is arst, synchronous, active-high; clock is clk. On the reset edge:
  - o_pc = RESET_VECTOR, FSM = BOOT.
  - o_pc_valid = 0, o_misaligned = 0, o_halted = 0.
  - All history entries = RESET_VECTOR; o_hist_count = 0; write pointer = 0.
  - arst overrides every other input in the same cycle, including in the middle of a redirect or halt.
- FSM states:
  - BOOT: one cycle only, o_pc_valid = 0, then go to RUN unconditionally.
  - RUN: o_pc_valid = 1.
  - HALTED: o_pc_valid = 0, o_halted = 1.
- Accept condition: a fetch is accepted when o_pc_valid && i_fetch_ready && !i_stall.
- Each clock edge in RUN applies the first matching rule, in this order:
  1. i_trap_valid: o_pc <= aligned(i_trap_vector).
  2. i_redirect_valid: o_pc <= aligned(i_redirect_pc).
  3. i_halt_req: go to HALTED; o_pc unchanged.
  4. Accept: o_pc <= o_pc + INSTR_BYTES, wrapping modulo 2^ADDR_WIDTH.
  5. Otherwise: hold o_pc.
- Trap and redirect ignore i_stall and i_fetch_ready.
- Each accepted fetch pushes the pre-update o_pc into the history. This push also happens when a trap or redirect fires in the same cycle, because that fetch completed.
- HALTED state:
  - i_trap_valid loads the trap vector and moves to RUN.
  - Otherwise i_resume moves to RUN with o_pc unchanged.
  - i_redirect_valid in HALTED loads o_pc and stays in HALTED.
  - i_halt_req in HALTED has no effect.
- Traps and redirects arriving in BOOT are ignored.
- Alignment: aligned(x) clears the low $clog2(INSTR_BYTES) bits of x. o_misaligned is registered and pulses high for the one cycle after a taken trap or redirect whose target had any nonzero low bits.
- History:
  - Circular buffer with write pointer wp; a push writes entry[wp] and sets wp <= wp+1, wrapping at HIST_DEPTH.
  - o_hist_pc = entry[(wp - 1 - i_hist_idx) mod HIST_DEPTH].
  - o_hist_count increments per push and saturates at HIST_DEPTH.
  - When i_hist_idx >= o_hist_count, o_hist_pc = RESET_VECTOR.

Test Plan:
- Reset, then 3 cycles with ready=1, stall=0:
  - Cycle 1 (BOOT): o_pc_valid = 0, o_pc = 0x3000_0000.
  - Following cycles: o_pc steps 0x3000_0000, 0x3000_0004, 0x3000_0008.
  - o_hist_count reaches 2; hist[0] = 0x3000_0004.
- In RUN with ready=1, stall=1 for 2 cycles: o_pc holds; no history push. Then assert redirect 0x4000_0010 with stall=1: next cycle o_pc = 0x4000_0010, o_misaligned = 0.
- Trap 0x8000_0100 and redirect 0x4000_0000 in the same cycle with ready=1 at pc 0x3000_0008:
  - o_pc becomes 0x8000_0100.
  - hist[0] = 0x3000_0008.
- Redirect to 0x4000_0013: o_pc = 0x4000_0010; o_misaligned high for exactly one cycle.
- i_halt_req at pc 0x3000_0004: o_halted = 1 and o_pc_valid = 0 next cycle. Redirect 0x5000_0000 while halted: stays halted, o_pc = 0x5000_0000. Then i_resume: RUN, fetch resumes at 0x5000_0000.
- Run 6 accepted fetches from reset:
  - o_hist_count saturates at 4.
  - hist[0..3] = 0x3000_0014, 0x3000_0010, 0x3000_000C, 0x3000_0008.
- Assert arst mid-halt: o_pc = 0x3000_0000, o_halted = 0, history cleared.
- Set o_pc = 0xFFFF_FFFC via redirect, then accept one fetch: o_pc wraps to 0x0000_0000.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage.
// Holds the fetch PC and drives a valid/ready fetch request. Redirects are
// applied in fixed priority: trap, then branch redirect, then halt, then the
// sequential advance. A small circular buffer records the most recently
// accepted fetch PCs for debug and exception reporting.
module pc_sequencer #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter logic [31:0] RESET_VECTOR = 32'h3000_0000,
   parameter int unsigned INSTR_BYTES  = 4,
   parameter int unsigned HIST_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          arst,
   input  logic                          i_fetch_ready,
   input  logic                          i_stall,
   input  logic                          i_redirect_valid,
   input  logic [ADDR_WIDTH-1:0]         i_redirect_pc,
   input  logic                          i_trap_valid,
   input  logic [ADDR_WIDTH-1:0]         i_trap_vector,
   input  logic                          i_halt_req,
   input  logic                          i_resume,
   input  logic [$clog2(HIST_DEPTH)-1:0] i_hist_idx,
   output logic [ADDR_WIDTH-1:0]         o_pc,
   output logic                          o_pc_valid,
   output logic                          o_misaligned,
   output logic                          o_halted,
   output logic [ADDR_WIDTH-1:0]         o_hist_pc,
   output logic [$clog2(HIST_DEPTH):0]   o_hist_count
);

   localparam int unsigned           IDX_W    = $clog2(HIST_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] RST_PC   = ADDR_WIDTH'(RESET_VECTOR);
   localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(INSTR_BYTES);
   // Low address bits that must be zero for an instruction-aligned PC.
   localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);
   localparam logic [IDX_W:0]        CNT_MAX  = (IDX_W + 1)'(HIST_DEPTH);

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t                  state, state_n;
   logic [ADDR_WIDTH-1:0]   pc, pc_n;
   logic                    mis_q, mis_n;
   logic                    accept;
   logic                    push;

   logic [ADDR_WIDTH-1:0]   hist [HIST_DEPTH];
   logic [IDX_W-1:0]        wp;
   logic [IDX_W:0]          cnt;
   logic [IDX_W-1:0]        rd_idx;

   function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] x);
      return x & ~LOW_MASK;
   endfunction

   function automatic logic is_misaligned(input logic [ADDR_WIDTH-1:0] x);
      return |(x & LOW_MASK);
   endfunction

   assign accept = (state == RUN) && i_fetch_ready && !i_stall;

   // Next-state, next-PC and history-push decode.
   always_comb begin
      state_n = state;
      pc_n    = pc;
      mis_n   = 1'b0;
      push    = 1'b0;
      unique case (state)
         BOOT: begin
            state_n = RUN;
         end
         RUN: begin
            // A fetch accepted in the same cycle as a redirect still completed.
            push = accept;
            if (i_trap_valid) begin
               pc_n  = align_pc(i_trap_vector);
               mis_n = is_misaligned(i_trap_vector);
            end else if (i_redirect_valid) begin
               pc_n  = align_pc(i_redirect_pc);
               mis_n = is_misaligned(i_redirect_pc);
            end else if (i_halt_req) begin
               state_n = HALTED;
            end else if (accept) begin
               pc_n = pc + STEP;
            end
         end
         HALTED: begin
            if (i_trap_valid) begin
               pc_n    = align_pc(i_trap_vector);
               mis_n   = is_misaligned(i_trap_vector);
               state_n = RUN;
            end else if (i_resume) begin
               state_n = RUN;
            end else if (i_redirect_valid) begin
               // Debugger-style PC load: the core stays halted.
               pc_n  = align_pc(i_redirect_pc);
               mis_n = is_misaligned(i_redirect_pc);
            end
         end
         default: begin
            state_n = BOOT;
         end
      endcase
   end

   // FSM state, PC and misalignment pulse registers.
   always_ff @(posedge clk) begin
      if (arst) begin
         state <= BOOT;
         pc    <= RST_PC;
         mis_q <= 1'b0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         mis_q <= mis_n;
      end
   end

   // History buffer: write the pre-update PC on each accepted fetch.
   always_ff @(posedge clk) begin
      if (arst) begin
         for (int i = 0; i < HIST_DEPTH; i++) begin
            hist[i] <= RST_PC;
         end
         wp  <= '0;
         cnt <= '0;
      end else if (push) begin
         hist[wp] <= pc;
         wp       <= wp + IDX_W'(1);
         if (cnt != CNT_MAX) begin
            cnt <= cnt + (IDX_W + 1)'(1);
         end
      end
   end

   // Index 0 is the newest entry; unfilled slots read as the reset vector.
   always_comb begin
      rd_idx = wp - IDX_W'(1) - i_hist_idx;
      if ({1'b0, i_hist_idx} >= cnt) begin
         o_hist_pc = RST_PC;
      end else begin
         o_hist_pc = hist[rd_idx];
      end
   end

   assign o_pc         = pc;
   assign o_pc_valid   = (state == RUN);
   assign o_halted     = (state == HALTED);
   assign o_misaligned = mis_q;
   assign o_hist_count = cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a scoreboard queue and a separate
// monitor that checks the registered outputs after every clock edge.
module tb_pc_sequencer;

   localparam logic [31:0] RV = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        arst = 1'b0;
   logic        i_fetch_ready = 1'b0;
   logic        i_stall = 1'b0;
   logic        i_redirect_valid = 1'b0;
   logic [31:0] i_redirect_pc = '0;
   logic        i_trap_valid = 1'b0;
   logic [31:0] i_trap_vector = '0;
   logic        i_halt_req = 1'b0;
   logic        i_resume = 1'b0;
   logic [1:0]  i_hist_idx = '0;
   logic [31:0] o_pc;
   logic        o_pc_valid;
   logic        o_misaligned;
   logic        o_halted;
   logic [31:0] o_hist_pc;
   logic [2:0]  o_hist_count;

   pc_sequencer dut (
      .clk              (clk),
      .arst             (arst),
      .i_fetch_ready    (i_fetch_ready),
      .i_stall          (i_stall),
      .i_redirect_valid (i_redirect_valid),
      .i_redirect_pc    (i_redirect_pc),
      .i_trap_valid     (i_trap_valid),
      .i_trap_vector    (i_trap_vector),
      .i_halt_req       (i_halt_req),
      .i_resume         (i_resume),
      .i_hist_idx       (i_hist_idx),
      .o_pc             (o_pc),
      .o_pc_valid       (o_pc_valid),
      .o_misaligned     (o_misaligned),
      .o_halted         (o_halted),
      .o_hist_pc        (o_hist_pc),
      .o_hist_count     (o_hist_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        v;
      logic        h;
      logic        m;
      logic [2:0]  cnt;
      logic        hc;
      logic [31:0] hpc;
   } exp_t;

   exp_t q[$];
   int   n_total = 0;
   int   n_pass  = 0;
   int   n_cyc   = 0;

   // Input values for the next cycle; restored to defaults after each cycle.
   logic        n_arst, n_rdy, n_stall, n_rv, n_tv, n_hr, n_rs;
   logic [31:0] n_rpc, n_tpc;
   logic [1:0]  n_idx;

   task automatic defaults();
      n_arst = 1'b0; n_rdy = 1'b1; n_stall = 1'b0; n_rv = 1'b0; n_tv = 1'b0;
      n_hr = 1'b0; n_rs = 1'b0; n_rpc = '0; n_tpc = '0; n_idx = '0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %h expected %h", name, n_cyc, act, exp);
   endtask

   // Apply the pending inputs for one clock and queue the expected post-edge outputs.
   task automatic cyc(input logic [31:0] e_pc, input logic e_v, input logic e_h,
                      input logic e_m, input logic [2:0] e_cnt,
                      input logic e_hc, input logic [31:0] e_hpc);
      exp_t e;
      @(negedge clk);
      arst = n_arst; i_fetch_ready = n_rdy; i_stall = n_stall;
      i_redirect_valid = n_rv; i_redirect_pc = n_rpc;
      i_trap_valid = n_tv; i_trap_vector = n_tpc;
      i_halt_req = n_hr; i_resume = n_rs; i_hist_idx = n_idx;
      e.pc = e_pc; e.v = e_v; e.h = e_h; e.m = e_m; e.cnt = e_cnt; e.hc = e_hc; e.hpc = e_hpc;
      q.push_back(e);
      @(posedge clk);
      defaults();
   endtask

   task automatic do_reset();
      n_arst = 1'b1;
      cyc(RV, 0, 0, 0, 3'd0, 1, RV);
      cyc(RV, 1, 0, 0, 3'd0, 0, '0);
   endtask

   // Monitor: compare DUT outputs shortly after every edge against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_cyc++;
            chk("pc", o_pc, e.pc);
            chk("pc_valid", 32'(o_pc_valid), 32'(e.v));
            chk("halted", 32'(o_halted), 32'(e.h));
            chk("misaligned", 32'(o_misaligned), 32'(e.m));
            chk("hist_count", 32'(o_hist_count), 32'(e.cnt));
            if (e.hc) chk("hist_pc", o_hist_pc, e.hpc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      defaults();
      // Reset, boot, two sequential fetches.
      do_reset();
      cyc(32'h3000_0004, 1, 0, 0, 3'd1, 1, RV);
      cyc(32'h3000_0008, 1, 0, 0, 3'd2, 1, 32'h3000_0004);
      // Stall holds the PC and pushes nothing; redirect ignores stall.
      n_stall = 1; cyc(32'h3000_0008, 1, 0, 0, 3'd2, 1, 32'h3000_0004);
      n_stall = 1; cyc(32'h3000_0008, 1, 0, 0, 3'd2, 0, '0);
      n_stall = 1; n_rv = 1; n_rpc = 32'h4000_0010;
      cyc(32'h4000_0010, 1, 0, 0, 3'd2, 0, '0);
      n_rdy = 0; cyc(32'h4000_0010, 1, 0, 0, 3'd2, 0, '0);

      // Trap beats redirect; the accepted fetch is still recorded.
      do_reset();
      cyc(32'h3000_0004, 1, 0, 0, 3'd1, 0, '0);
      cyc(32'h3000_0008, 1, 0, 0, 3'd2, 0, '0);
      n_tv = 1; n_tpc = 32'h8000_0100; n_rv = 1; n_rpc = 32'h4000_0000;
      cyc(32'h8000_0100, 1, 0, 0, 3'd3, 1, 32'h3000_0008);
      // Misaligned redirect: aligned target, one-cycle pulse.
      n_rdy = 0; n_rv = 1; n_rpc = 32'h4000_0013;
      cyc(32'h4000_0010, 1, 0, 1, 3'd3, 0, '0);
      n_rdy = 0; cyc(32'h4000_0010, 1, 0, 0, 3'd3, 0, '0);

      // Halt, PC load while halted, ignored halt, resume.
      do_reset();
      cyc(32'h3000_0004, 1, 0, 0, 3'd1, 0, '0);
      n_rdy = 0; n_hr = 1; cyc(32'h3000_0004, 0, 1, 0, 3'd1, 0, '0);
      n_rv = 1; n_rpc = 32'h5000_0000; cyc(32'h5000_0000, 0, 1, 0, 3'd1, 0, '0);
      n_hr = 1; cyc(32'h5000_0000, 0, 1, 0, 3'd1, 0, '0);
      n_rdy = 0; n_rs = 1; cyc(32'h5000_0000, 1, 0, 0, 3'd1, 0, '0);
      cyc(32'h5000_0004, 1, 0, 0, 3'd2, 1, 32'h5000_0000);
      n_rdy = 0; n_hr = 1; cyc(32'h5000_0004, 0, 1, 0, 3'd2, 1, 32'h5000_0000);

      // Reset while halted (with a redirect pending) wins over everything.
      n_arst = 1; n_rv = 1; n_rpc = 32'h6000_0000; n_idx = 2'd1;
      cyc(RV, 0, 0, 0, 3'd0, 1, RV);
      // Trap during BOOT is ignored.
      n_tv = 1; n_tpc = 32'h8000_0000; cyc(RV, 1, 0, 0, 3'd0, 0, '0);

      // Six accepted fetches: count saturates, history ordering.
      cyc(32'h3000_0004, 1, 0, 0, 3'd1, 1, RV);
      n_idx = 2'd3; cyc(32'h3000_0008, 1, 0, 0, 3'd2, 1, RV);
      n_idx = 2'd1; cyc(32'h3000_000C, 1, 0, 0, 3'd3, 1, 32'h3000_0004);
      cyc(32'h3000_0010, 1, 0, 0, 3'd4, 1, 32'h3000_000C);
      cyc(32'h3000_0014, 1, 0, 0, 3'd4, 1, 32'h3000_0010);
      cyc(32'h3000_0018, 1, 0, 0, 3'd4, 1, 32'h3000_0014);
      n_rdy = 0; n_idx = 2'd1; cyc(32'h3000_0018, 1, 0, 0, 3'd4, 1, 32'h3000_0010);
      n_rdy = 0; n_idx = 2'd2; cyc(32'h3000_0018, 1, 0, 0, 3'd4, 1, 32'h3000_000C);
      n_rdy = 0; n_idx = 2'd3; cyc(32'h3000_0018, 1, 0, 0, 3'd4, 1, 32'h3000_0008);

      // PC wrap at the top of the address space.
      n_rdy = 0; n_rv = 1; n_rpc = 32'hFFFF_FFFC;
      cyc(32'hFFFF_FFFC, 1, 0, 0, 3'd4, 0, '0);
      cyc(32'h0000_0000, 1, 0, 0, 3'd4, 1, 32'hFFFF_FFFC);

      // Misaligned trap out of HALTED returns to RUN.
      n_rdy = 0; n_hr = 1; cyc(32'h0000_0000, 0, 1, 0, 3'd4, 0, '0);
      n_tv = 1; n_tpc = 32'h8000_0102; cyc(32'h8000_0100, 1, 0, 1, 3'd4, 0, '0);
      n_rdy = 0; cyc(32'h8000_0100, 1, 0, 0, 3'd4, 0, '0);

      repeat (3) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         n_total++;
         $display("FAIL drain: %0d expected entries left, required 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
